// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches under a credit limit,
// and buffers returned words with their PCs for the decoder; redirects flush and drop in-flight data.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = CW + 1;

    logic          active;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] out_next;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] occupancy;
    logic [SW-1:0] credit_used;
    logic [AW-1:0] pc_wr;
    logic [AW-1:0] pc_rd;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   pc_mem   [FIFO_DEPTH];
    logic [31:0]   inst_mem [FIFO_DEPTH];
    logic [31:0]   ipc_mem  [FIFO_DEPTH];
    logic [31:0]   redirect_aligned;
    logic          accept;
    logic          rsp_take;
    logic          push;
    logic          pop;

    // Every in-flight request reserves a buffer slot, so a returning word always fits.
    assign credit_used      = {1'b0, outstanding} + {1'b0, occupancy};
    assign imem_req_valid   = active && !redirect_valid && (credit_used < SW'(FIFO_DEPTH));
    assign imem_req_addr    = fetch_pc;
    assign redirect_aligned = redirect_pc & ~32'h3;

    assign accept     = imem_req_valid && imem_req_ready;
    assign rsp_take   = imem_rsp_valid && (outstanding != '0);
    assign push       = rsp_take && (drop_cnt == '0) && !redirect_valid;
    assign inst_valid = (occupancy != '0);
    assign pop        = inst_valid && inst_ready;
    assign inst       = inst_mem[rd_ptr];
    assign inst_pc    = ipc_mem[rd_ptr];

    always_comb begin
        out_next = outstanding;
        if (accept && !rsp_take) begin
            out_next = outstanding + 1'b1;
        end else if (!accept && rsp_take) begin
            out_next = outstanding - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active      <= 1'b0;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            occupancy   <= '0;
            pc_wr       <= '0;
            pc_rd       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            active      <= 1'b1;
            outstanding <= out_next;
            if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
                pc_wr    <= pc_wr + 1'b1;
            end
            if (rsp_take) begin
                pc_rd <= pc_rd + 1'b1;
            end
            // The PC FIFO is kept across a redirect: in-flight responses still pop it.
            if (redirect_valid) begin
                fetch_pc  <= redirect_aligned;
                drop_cnt  <= out_next;
                occupancy <= '0;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
            end else begin
                if (rsp_take && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    occupancy <= occupancy + 1'b1;
                end else if (!push && pop) begin
                    occupancy <= occupancy - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
                ipc_mem[i]  <= '0;
            end
        end else begin
            if (accept) begin
                pc_mem[pc_wr] <= fetch_pc;
            end
            if (push) begin
                inst_mem[wr_ptr] <= imem_rsp_data;
                ipc_mem[wr_ptr]  <= pc_mem[pc_rd];
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: the expected stream is "consecutive words from
// the last restart PC", flushed on every redirect or reset, and checked as decode consumes it.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] pc; logic [31:0] word; } exp_t;
    typedef struct packed { logic [31:0] word; int due; } rsp_t;

    exp_t        sb[$];
    rsp_t        mem_q[$];
    int          checks = 0;
    int          passed = 0;
    int          cyc = 0;
    int          pops = 0;
    int          accepts = 0;
    logic [31:0] exp_req_pc = RESET_PC;
    int          ready_pct = 100;
    int          inst_ready_pct = 100;
    int          redirect_pct = 0;
    int          rsp_pct = 100;
    int          lat_max = 1;
    bit          force_redir = 1'b0;
    logic [31:0] force_target = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every word decode consumes must be the next one of the expected stream.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && inst_valid && inst_ready) begin
            pops++;
            if (sb.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_inst: got pc %h, expected no instruction", inst_pc);
            end else begin
                e = sb.pop_front();
                check_output("inst_pc", inst_pc, e.pc);
                check_output("inst", inst, e.word);
            end
        end
    end

    task automatic apply_stimulus();
        logic [31:0] target;
        @(posedge clk);
        #1;
        cyc++;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc && $urandom_range(0, 99) < rsp_pct) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_q[0].word;
            void'(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        imem_req_ready = ($urandom_range(0, 99) < ready_pct);
        inst_ready     = ($urandom_range(0, 99) < inst_ready_pct);
        if (force_redir || $urandom_range(0, 99) < redirect_pct) begin
            target = $urandom;
            if ($urandom_range(0, 3) == 0) target = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            redirect_valid = 1'b1;
            redirect_pc    = force_redir ? force_target : target;
            force_redir    = 1'b0;
        end else begin
            redirect_valid = 1'b0;
            redirect_pc    = $urandom;
        end
        @(negedge clk);
        #1;
        if (redirect_valid) begin
            check_output("req_valid_in_redirect", 32'(imem_req_valid), 32'd0);
            sb.delete();
            exp_req_pc = redirect_pc & ~32'h3;
        end else if (imem_req_valid && imem_req_ready) begin
            accepts++;
            check_output("req_addr", imem_req_addr, exp_req_pc);
            sb.push_back('{pc: exp_req_pc, word: mem_word(exp_req_pc)});
            mem_q.push_back('{word: mem_word(imem_req_addr), due: cyc + $urandom_range(1, lat_max)});
            exp_req_pc = exp_req_pc + 32'd4;
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_output("rst_inst_valid", 32'(inst_valid), 32'd0);
        check_output("rst_inst", inst, 32'd0);
        check_output("rst_inst_pc", inst_pc, 32'd0);
        sb.delete();
        mem_q.delete();
        exp_req_pc     = RESET_PC;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int p0;
        int budget;
        #12;
        check_output("reset_req_valid", 32'(imem_req_valid), 32'd0);
        check_output("reset_inst_valid", 32'(inst_valid), 32'd0);
        check_output("reset_inst", inst, 32'd0);
        check_output("reset_inst_pc", inst_pc, 32'd0);
        rst_n = 1'b1;

        // Decode stalled: only DEPTH requests may be issued before fetch stops.
        inst_ready_pct = 0;
        accepts = 0;
        repeat (12) apply_stimulus();
        check_output("stall_accepts", 32'(accepts), 32'(DEPTH));
        check_output("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check_output("stall_inst_valid", 32'(inst_valid), 32'd1);

        // Zero-wait memory and free-running decode: one instruction per cycle.
        inst_ready_pct = 100;
        repeat (10) apply_stimulus();
        p0 = pops;
        repeat (20) apply_stimulus();
        check_output("throughput", 32'(pops - p0), 32'd20);

        // Redirect with responses in flight, then a redirect that wraps the address space.
        force_redir = 1'b1;
        force_target = 32'h0000_0203;
        repeat (12) apply_stimulus();
        force_redir = 1'b1;
        force_target = 32'hFFFF_FFF4;
        repeat (12) apply_stimulus();

        ready_pct = 70;
        inst_ready_pct = 70;
        redirect_pct = 3;
        rsp_pct = 70;
        lat_max = 3;
        repeat (1500) apply_stimulus();
        pulse_reset();
        repeat (1500) apply_stimulus();

        // Drain: stop accepting requests and let every buffered word reach decode.
        ready_pct = 0;
        redirect_pct = 0;
        inst_ready_pct = 100;
        rsp_pct = 100;
        budget = 0;
        while ((mem_q.size() != 0 || inst_valid) && budget < 200) begin
            apply_stimulus();
            budget++;
        end
        check_output("drain_timeout", 32'(budget < 200), 32'd1);
        check_output("drain_leftover", 32'(sb.size()), 32'd0);
        check_output("progress", 32'(pops > 100), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
